// File: rtl/rect_rasterizer.sv
// rect_rasterizer: streams a clipped filled rectangle as one frame-buffer write per clock,
// row-major, with a one-cycle done pulse per command.
module rect_rasterizer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [8:0] req_x0,
  input  logic [8:0] req_y0,
  input  logic [7:0] req_w,
  input  logic [6:0] req_h,
  input  logic [8:0] req_colour,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic [8:0] colour,
  output logic       draw_en,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state, state_nx;
  logic [8:0] x0, y0, col, rem_x, rem_y, bx0, by0, bcol;
  logic [7:0] cw, cx, clip_w, bcw, bcx;
  logic [6:0] ch, cy, clip_h, bcy;
  logic accept, empty, fin, wrap, issue;
  assign req_ready = state == IDLE;
  assign rem_x = 9'(SCREEN_W) - req_x0;
  assign rem_y = 9'(SCREEN_H) - req_y0;
  // The acceptance edge already issues pixel 0, so counters always point at the next pixel
  always_comb begin
    clip_w = (req_x0 >= 9'(SCREEN_W)) ? 8'd0 : ({1'b0, req_w} < rem_x) ? req_w : rem_x[7:0];
    clip_h = (req_y0 >= 9'(SCREEN_H)) ? 7'd0 : ({2'b0, req_h} < rem_y) ? req_h : rem_y[6:0];
    accept = req_ready && req_valid;
    empty = clip_w == 8'd0 || clip_h == 7'd0;
    fin = cy == ch;
    bx0 = req_ready ? req_x0 : x0;
    by0 = req_ready ? req_y0 : y0;
    bcol = req_ready ? req_colour : col;
    bcw = req_ready ? clip_w : cw;
    bcx = req_ready ? 8'd0 : cx;
    bcy = req_ready ? 7'd0 : cy;
    wrap = bcx == bcw - 8'd1;
    issue = accept ? !empty : (state == DRAW && !fin);
    state_nx = accept ? (empty ? DONE : DRAW) : (state == DRAW) ? (fin ? DONE : DRAW) : IDLE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x0 <= '0;
      y0 <= '0;
      col <= '0;
      cw <= '0;
      ch <= '0;
      cx <= '0;
      cy <= '0;
      x <= '0;
      y <= '0;
      colour <= '0;
      draw_en <= 1'b0;
      done <= 1'b0;
    end else begin
      draw_en <= issue;
      done <= (accept && empty) || (state == DRAW && fin);
      if (accept) begin
        x0 <= req_x0;
        y0 <= req_y0;
        col <= req_colour;
        cw <= clip_w;
        ch <= clip_h;
      end
      if (issue) begin
        x <= bx0 + {1'b0, bcx};
        y <= by0 + {2'b0, bcy};
        colour <= bcol;
        cx <= wrap ? 8'd0 : bcx + 8'd1;
        cy <= wrap ? bcy + 7'd1 : bcy;
      end
    end
  end
endmodule

// File: doc/rect_rasterizer.md
# rect_rasterizer

Pixel-stream generator between the game-state logic and the VGA frame-buffer adapter. It accepts one filled-rectangle draw command at a time (origin, size, colour) and emits one frame-buffer write per clock, row-major, on the adapter's `x`/`y`/`colour`/`plot` inputs. Rectangles are clipped to the 160x120 screen. A one-cycle `done` pulse lets the game-state FSM sequence tile draws and erasures.

## Interface
- `SCREEN_W`, default 160: visible width in pixels.
- `SCREEN_H`, default 120: visible height in pixels.

- `clk`  in  1  system clock (CLOCK_50 domain); the block's only clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  block can accept a command (high only in IDLE).
- `req_x0`  in  9  left column of the rectangle.
- `req_y0`  in  9  top row of the rectangle.
- `req_w`  in  8  width in pixels; 0 means empty.
- `req_h`  in  7  height in pixels; 0 means empty.
- `req_colour`  in  9  3-3-3 RGB fill colour.
- `x`  out  9  pixel column to the VGA adapter.
- `y`  out  9  pixel row to the VGA adapter.
- `colour`  out  9  pixel colour to the VGA adapter.
- `draw_en`  out  1  plot strobe; one pixel is written per high cycle.
- `done`  out  1  one-cycle pulse after the last pixel of a command (or after acceptance of an empty command).

## Operation
- States: IDLE, DRAW, DONE.
- **IDLE**
  - `req_ready=1`.
  - When `req_valid && req_ready` at a rising edge, latch all request fields and compute the clipped extents:
    - cw = min(req_w, SCREEN_W−req_x0); cw = 0 if req_x0 ≥ SCREEN_W.
    - ch = min(req_h, SCREEN_H−req_y0); ch = 0 if req_y0 ≥ SCREEN_H.
  - If cw or ch is 0, go to DONE. Otherwise go to DRAW with column counter cx=0 and row counter cy=0.
- **DRAW**
  - Each cycle, register `x=x0+cx`, `y=y0+cy`, `colour=latched colour`, `draw_en=1`.
  - Advance cx. When cx=cw−1, wrap cx to 0 and increment cy.
  - After the pixel (cw−1, ch−1) has been issued, go to DONE.
- **DONE**
  - `done=1` and `draw_en=0` for exactly one cycle, then return to IDLE.
- `req_*` inputs are ignored outside IDLE. The requester holds a command until it sees `req_ready`.
- Arithmetic:
  - Sums are 9-bit.
  - Clipping guarantees x0+cx < SCREEN_W and y0+cy < SCREEN_H, so no wrap-around ever reaches the outputs.
  - Counters are 8 bits (cx) and 7 bits (cy).
- `colour` is held constant for a whole command. `x`, `y` and `colour` retain their last values when `draw_en=0`.

## Timing
- Reset values (applied asynchronously): state IDLE, `req_ready=1`, `x=0`, `y=0`, `colour=0`, `draw_en=0`, `done=0`.
- Outputs `x`, `y`, `colour`, `draw_en` and `done` are registered. `req_ready` is decoded from state.
- Acceptance at edge k:
  - The first pixel is valid (`draw_en=1`) in the cycle after edge k.
  - Pixel n (0-based) appears n cycles later.
  - `done` is high in cycle k+cw·ch+1.
  - `req_ready` is high again in cycle k+cw·ch+2.
- An empty or fully off-screen command produces no pixels. `done` is high in the cycle after acceptance, and `req_ready` returns one cycle later.
- Throughput is one pixel per clock with no gaps inside a command. Back-to-back commands incur a 2-cycle gap (DONE + IDLE).
- Reset mid-DRAW aborts the command:
  - `draw_en` and `done` drop asynchronously.
  - Remaining pixels are never issued and no `done` pulse is produced.
- `req_valid` asserted during DRAW or DONE has no effect until IDLE. A request already present when IDLE is entered is accepted on the first IDLE edge.

## Test plan
- **After reset:** command (x0=10, y0=20, w=3, h=2, colour=9'h1C0) → `draw_en` high for exactly 6 cycles, in the order (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), all with colour 1C0. `done` is high in the 7th cycle after acceptance.
- **Right/bottom clip:** (x0=158, y0=118, w=5, h=5) → 4 pixels: (158,118) (159,118) (158,119) (159,119), then `done`.
- **Empty and off-screen commands:** w=0; h=0; x0=160; y0=200 → each produces no `draw_en` pulse. `done` is high one cycle after acceptance and `req_ready` is high two cycles after acceptance.
- **Back-to-back:** hold `req_valid` with two 1x1 commands → pixels 3 cycles apart. Inputs changed during DRAW have no effect on the current command.
- **Reset mid-operation:** full-screen clear (0, 0, 160, 120, colour 0) with `resetn` pulsed low after 500 pixels → `draw_en=0` and `done=0` immediately, `req_ready=1`, no further pixels.
- **Full-screen clear:** (0, 0, 160, 120) → exactly 19200 pixels, the last at (159,119), with `done` at cycle 19201 after acceptance.
